ram2p1r1wbe_sweep: RTL and testbench

//  Parametrised 1-read/1-write two-port SRAM model with per-byte write enables, one clock.

---
 rtl/ram2p1r1wbe_sweep_pkg.sv | 7 +
 rtl/ram2p1r1wbe_sweep_if.sv | 19 +
 rtl/ram2p1r1wbe_sweep_bytelane.sv | 20 ++
 rtl/ram2p1r1wbe_sweep.sv | 97 +++++++++
 tb/tb_ram2p1r1wbe_sweep.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/ram2p1r1wbe_sweep_pkg.sv
// ram2p1r1wbe_sweep_pkg: sweep FSM state type and byte parity helper shared by the RAM model
package ram2p1r1wbe_sweep_pkg;
    typedef enum logic {INIT, RUN} ram2p_state_t;
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/ram2p1r1wbe_sweep_if.sv
// ram2p1r1wbe_sweep_if: read/write port bundle of the two-port RAM (master drives, slave is the RAM)
interface ram2p1r1wbe_sweep_if #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 64
);
    localparam int AW = $clog2(DEPTH);
    logic             ready;
    logic             ce1;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] rd1;
    logic             ce2;
    logic [AW-1:0]    wa2;
    logic [WIDTH-1:0] wd2;
    logic [WIDTH/8-1:0] bwe2;
    logic             inj_par;
    logic             parity_err;
    modport master (input ready, rd1, parity_err, output ce1, ra1, ce2, wa2, wd2, bwe2, inj_par);
    modport slave  (output ready, rd1, parity_err, input ce1, ra1, ce2, wa2, wd2, bwe2, inj_par);
endinterface

// File: rtl/ram2p1r1wbe_sweep_bytelane.sv
// ram2p1r1wbe_sweep_bytelane: one byte lane (plus parity bit when LW=9) of DEPTH entries
module ram2p1r1wbe_sweep_bytelane #(
    parameter int DEPTH = 128,
    parameter int LW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [LW-1:0] i_wd,
    input  logic [AW-1:0] i_ra,
    output logic [LW-1:0] o_rd
);
    logic [LW-1:0] r_mem [DEPTH];
    // Lane storage; range checks, byte enables and sweep override are resolved by the top
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wa] <= i_wd;
    end
    assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/ram2p1r1wbe_sweep.sv
// ram2p1r1wbe_sweep: 1R1W byte-enable SRAM with post-reset zeroing sweep; RAM2P_PARITY_EN adds per-byte even parity
module ram2p1r1wbe_sweep
    import ram2p1r1wbe_sweep_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WIDTH       = 64,
    parameter bit READ_BYPASS = 1'b1
) (
    input logic clk,
    input logic reset,
    ram2p1r1wbe_sweep_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
`ifdef RAM2P_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    ram2p_state_t     r_state, w_state_nxt;
    logic [AW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_rd1, w_rd_nxt;
    logic             w_init, w_ready, w_wa_ok, w_ra_ok, w_hit;
    logic [AW-1:0]    w_wa;
    logic [NB-1:0]    w_lane_we;
    logic [LW-1:0]    w_lane_wd [NB];
    logic [LW-1:0]    w_lane_rd [NB];
    logic [LW-1:0]    w_lane_q  [NB];
    assign w_init  = (r_state == INIT);
    assign w_ready = (r_state == RUN);
    assign w_wa_ok = {1'b0, bus.wa2} < DEPTH_W;
    assign w_ra_ok = {1'b0, bus.ra1} < DEPTH_W;
    assign w_hit   = READ_BYPASS && bus.ce2 && w_wa_ok && (bus.wa2 == bus.ra1);
    assign w_wa    = w_init ? r_cnt : bus.wa2;
    // Sweep FSM state and sweep address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    // Sweep clears one address per cycle and enters RUN after writing the last word
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_init) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if ({1'b0, r_cnt} == DEPTH_W - 1'b1) w_state_nxt = RUN;
        end
    end
    for (genvar i = 0; i < NB; i++) begin : g_lane
`ifdef RAM2P_PARITY_EN
        assign w_lane_wd[i] = w_init ? '0 : {byte_parity(bus.wd2[8*i+:8]) ^ bus.inj_par, bus.wd2[8*i+:8]};
`else
        assign w_lane_wd[i] = w_init ? '0 : bus.wd2[8*i+:8];
`endif
        assign w_lane_we[i] = w_init || (bus.ce2 && bus.bwe2[i] && w_wa_ok);
        assign w_lane_q[i]  = !w_ra_ok ? '0 : (w_hit && bus.bwe2[i]) ? w_lane_wd[i] : w_lane_rd[i];
        assign w_rd_nxt[8*i+:8] = w_lane_q[i][7:0];
        ram2p1r1wbe_sweep_bytelane #(.DEPTH(DEPTH), .LW(LW), .AW(AW)) u_lane (
            .clk  (clk),
            .i_we (w_lane_we[i]),
            .i_wa (w_wa),
            .i_wd (w_lane_wd[i]),
            .i_ra (bus.ra1),
            .o_rd (w_lane_rd[i])
        );
    end
    // Read data updates only on an accepted read and holds otherwise
    always_ff @(posedge clk) begin
        if (reset) r_rd1 <= '0;
        else if (w_ready && bus.ce1) r_rd1 <= w_rd_nxt;
    end
    assign bus.ready = w_ready;
    assign bus.rd1   = r_rd1;
`ifdef RAM2P_PARITY_EN
    logic          r_perr;
    logic [NB-1:0] w_perr;
    for (genvar i = 0; i < NB; i++) begin : g_par
        assign w_perr[i] = w_lane_q[i][8] ^ byte_parity(w_lane_q[i][7:0]);
    end
    // Parity flag is captured and held together with rd1
    always_ff @(posedge clk) begin
        if (reset) r_perr <= 1'b0;
        else if (w_ready && bus.ce1) r_perr <= |w_perr;
    end
    assign bus.parity_err = r_perr;
`else
    logic w_unused_inj;
    assign w_unused_inj   = bus.inj_par;
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ram2p1r1wbe_sweep.sv
// tb_ram2p1r1wbe_sweep: directed vectors with a read-data scoreboard for ram2p1r1wbe_sweep
module tb_ram2p1r1wbe_sweep;
    localparam bit RB = 1'b1;
    typedef struct {
        string       nm;
        logic [63:0] d;
        logic        p;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vec = 0;
    int   bad = 0;
    logic pend = 1'b0;
    exp_t sbq [$];
    ram2p1r1wbe_sweep_if #(.DEPTH(128), .WIDTH(64)) bus ();
    ram2p1r1wbe_sweep #(.DEPTH(128), .WIDTH(64), .READ_BYPASS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) pend <= bus.ce1 && bus.ready && !reset;
    always @(negedge clk) begin
        if (pend) begin
            vec++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read rd1=%h with empty scoreboard", bus.rd1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.rd1 !== e.d || bus.parity_err !== e.p) begin
                    bad++;
                    $display("FAIL %s rd1=%h perr=%b expected rd1=%h perr=%b", e.nm, bus.rd1, bus.parity_err, e.d, e.p);
                end
            end
        end
    end
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vec++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, want);
        end
    endtask
    task automatic idle();
        bus.ce1 = 1'b0; bus.ra1 = '0; bus.ce2 = 1'b0; bus.wa2 = '0;
        bus.wd2 = '0; bus.bwe2 = '0; bus.inj_par = 1'b0;
    endtask
    task automatic wr(input logic [6:0] a, input logic [63:0] d, input logic [7:0] be, input logic inj);
        bus.ce2 = 1'b1; bus.wa2 = a; bus.wd2 = d; bus.bwe2 = be; bus.inj_par = inj;
        @(negedge clk);
        idle();
    endtask
    task automatic rd(input logic [6:0] a, input logic [63:0] d, input logic p, input string nm);
        bus.ce1 = 1'b1; bus.ra1 = a;
        sbq.push_back('{nm, d, p});
        @(negedge clk);
        idle();
    endtask
    task automatic rw(input logic [6:0] a, input logic [63:0] d, input logic [7:0] be, input logic inj,
                      input logic [63:0] ed, input logic ep, input string nm);
        bus.ce1 = 1'b1; bus.ra1 = a;
        bus.ce2 = 1'b1; bus.wa2 = a; bus.wd2 = d; bus.bwe2 = be; bus.inj_par = inj;
        sbq.push_back('{nm, ed, ep});
        @(negedge clk);
        idle();
    endtask
    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 64'(n), 64'd128);
        @(negedge clk);
    endtask
    initial begin
        #100000;
        bad++;
        $display("FAIL timeout vectors=%0d", vec);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
    initial begin
        idle();
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_rd1", bus.rd1, 64'd0);
        chk("rst_perr", 64'(bus.parity_err), 64'd0);
        reset = 1'b0;
        wait_ready("sweep_len");
        rd(7'd0, 64'd0, 1'b0, "init_rd0");
        rd(7'd127, 64'd0, 1'b0, "init_rd127");
        wr(7'd5, 64'h1122334455667788, 8'hFF, 1'b0);
        rd(7'd5, 64'h1122334455667788, 1'b0, "full_write");
        wr(7'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0);
        rd(7'd5, 64'h11223344FFFFFFFF, 1'b0, "byte_write");
        rw(7'd9, 64'hABABABABABABABAB, 8'hFF, 1'b0, RB ? 64'hABABABABABABABAB : 64'd0, 1'b0, "collide_full");
        rd(7'd9, 64'hABABABABABABABAB, 1'b0, "after_collide");
        rw(7'd5, 64'd0, 8'hF0, 1'b0, RB ? 64'h00000000FFFFFFFF : 64'h11223344FFFFFFFF, 1'b0, "collide_part");
        rd(7'd5, 64'h00000000FFFFFFFF, 1'b0, "after_part");
        wr(7'd9, 64'd0, 8'h00, 1'b0);
        rd(7'd9, 64'hABABABABABABABAB, 1'b0, "bwe_zero_noop");
        wr(7'd127, 64'hDEADBEEF01234567, 8'hFF, 1'b0);
        rd(7'd127, 64'hDEADBEEF01234567, 1'b0, "top_addr");
        rd(7'd126, 64'd0, 1'b0, "below_top");
        wr(7'd127, 64'd0, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("rd1_hold", bus.rd1, 64'd0);
        rd(7'd127, 64'd0, 1'b0, "top_cleared");
        wr(7'd5, 64'h5555555555555555, 8'hFF, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("run_rst_ready", 64'(bus.ready), 64'd0);
        chk("run_rst_rd1", bus.rd1, 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bus.ce2 = 1'b1; bus.wa2 = k[0] ? 7'd100 : 7'd0;
            bus.wd2 = '1; bus.bwe2 = '1;
            bus.ce1 = 1'b1; bus.ra1 = 7'd0;
            @(negedge clk);
            if (k % 8 == 7) begin
                chk("init_ready_low", 64'(bus.ready), 64'd0);
                chk("init_rd1_zero", bus.rd1, 64'd0);
            end
        end
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready("resweep_len");
        rd(7'd0, 64'd0, 1'b0, "init_wr_dropped0");
        rd(7'd100, 64'd0, 1'b0, "init_wr_dropped100");
        rd(7'd5, 64'd0, 1'b0, "resweep_clr5");
        rd(7'd9, 64'd0, 1'b0, "resweep_clr9");
`ifdef RAM2P_PARITY_EN
        wr(7'd3, 64'h00000000000000A5, 8'h01, 1'b1);
        rd(7'd3, 64'h00000000000000A5, 1'b1, "par_inject");
        wr(7'd3, 64'h00000000000000A5, 8'h01, 1'b0);
        rd(7'd3, 64'h00000000000000A5, 1'b0, "par_clean");
        rw(7'd4, 64'h0000000000000001, 8'h01, 1'b1, RB ? 64'h1 : 64'h0, RB, "par_bypass");
        rd(7'd4, 64'h0000000000000001, 1'b1, "par_stored");
`endif
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
